// File: rtl/hbmc_pkg.sv
// Shared constants and gray-code helpers for the HyperBus read-data path.
package hbmc_pkg;

  localparam int HB_WORD_W    = 16;
  localparam int HB_DQ_W      = 8;
  // Widest pointer supported (FIFO_DEPTH = 256 -> 8 address bits + wrap bit).
  localparam int HB_PTR_MAX_W = 9;

  // Binary to reflected gray code; narrower pointers are zero-extended first.
  function automatic logic [HB_PTR_MAX_W-1:0] bin2gray(input logic [HB_PTR_MAX_W-1:0] bin);
    return bin ^ {1'b0, bin[HB_PTR_MAX_W-1:1]};
  endfunction

  // Reflected gray code back to binary.
  function automatic logic [HB_PTR_MAX_W-1:0] gray2bin(input logic [HB_PTR_MAX_W-1:0] gray);
    logic [HB_PTR_MAX_W-1:0] bin;
    bin[HB_PTR_MAX_W-1] = gray[HB_PTR_MAX_W-1];
    for (int i = HB_PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/hbmc_gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer; clock edge selectable so
// the same cell serves the rising-edge and falling-edge domains.
module hbmc_gray_sync #(
  parameter int WIDTH    = 5,
  parameter int STAGES   = 2,
  parameter bit NEG_EDGE = 1'b0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

  generate
    if (NEG_EDGE) begin : g_neg
      // Falling-edge shift chain, cleared by the asynchronous reset.
      always_ff @(negedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
    end else begin : g_pos
      // Rising-edge shift chain, cleared by the asynchronous reset.
      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
    end
  endgenerate

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hbmc_rd_fifo.sv
// HyperBus read-data elastic buffer: packs DQ SDR pairs into 16-bit words on
// the IDDR clock (falling edge), crosses them through a gray-pointer async
// FIFO and presents them as a first-word-fall-through stream on rd_clk.
module hbmc_rd_fifo
  import hbmc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 arst,
  input  logic                 wr_clk,
  input  logic                 rd_clk,
  input  logic [HB_WORD_W-1:0] dq_sdr,
  input  logic                 dq_we,
  output logic [HB_WORD_W-1:0] dout,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic                 wr_full,
  output logic                 wr_ovf,
  output logic                 rd_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [HB_WORD_W-1:0] mem_q [FIFO_DEPTH];

  logic [HB_WORD_W-1:0] word_s;
  logic                 wr_en_s;
  logic [PW-1:0]        wbin_q, wbin_d, wgray_q, wgray_d;
  logic [PW-1:0]        rgray_wsync_s, full_target_s;
  logic                 wr_full_q, wr_full_d, wr_ovf_q, wr_ovf_d;

  logic                 pop_s;
  logic [PW-1:0]        rbin_q, rbin_d, rgray_q, rgray_d;
  logic [PW-1:0]        wgray_rsync_s;
  logic                 rd_empty_q, rd_empty_d;

  // Per pin: first beat goes to the upper byte, second beat to the lower byte.
  always_comb begin
    word_s = '0;
    for (int n = 0; n < HB_DQ_W; n++) begin
      word_s[HB_DQ_W+n] = dq_sdr[2*n+1];
      word_s[n]         = dq_sdr[2*n];
    end
  end

  // Write-side next state; full compares against the synchronised read
  // pointer, so it can only release late, never early.
  always_comb begin
    wr_en_s       = dq_we && !wr_full_q;
    wbin_d        = wbin_q + {{AW{1'b0}}, wr_en_s};
    wgray_d       = PW'(bin2gray(HB_PTR_MAX_W'(wbin_d)));
    full_target_s = {~rgray_wsync_s[AW:AW-1], rgray_wsync_s[AW-2:0]};
    wr_full_d     = (wgray_d == full_target_s);
    wr_ovf_d      = wr_ovf_q | (dq_we & wr_full_q);
  end

  // Write-side pointer and flag registers (falling edge of the IDDR clock).
  always_ff @(negedge wr_clk or posedge arst) begin
    if (arst) begin
      wbin_q    <= '0;
      wgray_q   <= '0;
      wr_full_q <= 1'b0;
      wr_ovf_q  <= 1'b0;
    end else begin
      wbin_q    <= wbin_d;
      wgray_q   <= wgray_d;
      wr_full_q <= wr_full_d;
      wr_ovf_q  <= wr_ovf_d;
    end
  end

  // Storage array; contents are not reset, reads are masked while empty.
  always_ff @(negedge wr_clk) begin
    if (wr_en_s) mem_q[wbin_q[AW-1:0]] <= word_s;
  end

  hbmc_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES), .NEG_EDGE(1'b0)) u_w2r_sync (
    .clk_i  (rd_clk),
    .arst_i (arst),
    .d_i    (wgray_q),
    .q_o    (wgray_rsync_s)
  );

  hbmc_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES), .NEG_EDGE(1'b1)) u_r2w_sync (
    .clk_i  (wr_clk),
    .arst_i (arst),
    .d_i    (rgray_q),
    .q_o    (rgray_wsync_s)
  );

  // Read-side next state; empty looks ahead at the post-pop pointer.
  always_comb begin
    pop_s      = !rd_empty_q && dout_rdy;
    rbin_d     = rbin_q + {{AW{1'b0}}, pop_s};
    rgray_d    = PW'(bin2gray(HB_PTR_MAX_W'(rbin_d)));
    rd_empty_d = (rgray_d == wgray_rsync_s);
  end

  // Read-side pointer and empty flag registers (rising edge of rd_clk).
  always_ff @(posedge rd_clk or posedge arst) begin
    if (arst) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      rd_empty_q <= 1'b1;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      rd_empty_q <= rd_empty_d;
    end
  end

  // Fall-through output straight from the array, forced to zero when empty.
  always_comb begin
    if (rd_empty_q) begin
      dout = '0;
    end else begin
      dout = mem_q[rbin_q[AW-1:0]];
    end
  end

  assign dout_vld = !rd_empty_q;
  assign rd_empty = rd_empty_q;
  assign wr_full  = wr_full_q;
  assign wr_ovf   = wr_ovf_q;

endmodule

// File: tb/tb_hbmc_rd_fifo.sv
// Self-checking bench for hbmc_rd_fifo: packing table, fill/overflow,
// backpressure, latency, randomised dual-clock stream and mid-run reset.
module tb_hbmc_rd_fifo;

  logic        arst, wr_clk, rd_clk;
  logic [15:0] dq_sdr;
  logic        dq_we;
  logic [15:0] dout;
  logic        dout_vld, dout_rdy;
  logic        wr_full, wr_ovf, rd_empty;

  int total = 0;
  int bad   = 0;
  int rd_edges = 0;
  int wr_mark  = 0;
  logic [15:0] mq[$];

  typedef struct {
    logic [15:0] sdr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[6];

  hbmc_rd_fifo #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .arst     (arst),
    .wr_clk   (wr_clk),
    .rd_clk   (rd_clk),
    .dq_sdr   (dq_sdr),
    .dq_we    (dq_we),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .wr_full  (wr_full),
    .wr_ovf   (wr_ovf),
    .rd_empty (rd_empty)
  );

  // wr_clk twice the rate of rd_clk; rd_clk offset so edges never coincide.
  initial begin
    wr_clk = 1'b0;
    forever #2 wr_clk = ~wr_clk;
  end
  initial begin
    rd_clk = 1'b0;
    #1;
    forever #4 rd_clk = ~rd_clk;
  end

  always @(posedge rd_clk) rd_edges <= rd_edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // dq_sdr pattern that the packing rule turns into word w.
  function automatic logic [15:0] sdr_for(input logic [15:0] w);
    logic [15:0] s;
    for (int n = 0; n < 8; n++) begin
      s[2*n+1] = w[8+n];
      s[2*n]   = w[n];
    end
    return s;
  endfunction

  task automatic wr_word(input logic [15:0] sdr);
    @(posedge wr_clk);
    dq_sdr = sdr;
    dq_we  = 1'b1;
    @(negedge wr_clk);
    wr_mark = rd_edges;
    @(posedge wr_clk);
    dq_we = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [15:0] exp);
    int n = 0;
    @(negedge rd_clk);
    while (!dout_vld && n < 50) begin
      @(negedge rd_clk);
      n++;
    end
    check({name, "_vld"}, 32'(dout_vld), 32'd1);
    check(name, 32'(dout), 32'(exp));
    dout_rdy = 1'b1;
    @(negedge rd_clk);
    dout_rdy = 1'b0;
  endtask

  task automatic settle_empty(input string name);
    repeat (6) @(negedge rd_clk);
    check({name, "_empty"}, 32'(rd_empty), 32'd1);
    check({name, "_dout0"}, 32'(dout), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'hAAAA, 16'hFF00};
    vecs[1] = '{16'h5555, 16'h00FF};
    vecs[2] = '{16'h0002, 16'h0100};
    vecs[3] = '{16'h4000, 16'h0080};
    vecs[4] = '{16'hF00F, 16'hC3C3};
    vecs[5] = '{16'h1234, 16'h1446};

    arst = 1'b1; dq_we = 1'b0; dq_sdr = 16'h0000; dout_rdy = 1'b0;
    #20;
    arst = 1'b0;

    // Reset state
    @(negedge rd_clk);
    check("rst_vld",   32'(dout_vld), 32'd0);
    check("rst_empty", 32'(rd_empty), 32'd1);
    check("rst_full",  32'(wr_full),  32'd0);
    check("rst_ovf",   32'(wr_ovf),   32'd0);
    check("rst_dout",  32'(dout),     32'd0);

    // Packing table
    for (int i = 0; i < 6; i++) wr_word(vecs[i].sdr);
    for (int i = 0; i < 6; i++) pop_expect($sformatf("pack%0d", i), vecs[i].exp);
    settle_empty("pack");

    // Fill and overflow with the reader blocked
    for (int i = 0; i < 17; i++) begin
      wr_word(sdr_for(16'(i)));
      if (i == 14) check("full_before", 32'(wr_full), 32'd0);
      if (i == 15) begin
        check("full_at15", 32'(wr_full), 32'd1);
        check("ovf_at15",  32'(wr_ovf),  32'd0);
      end
      if (i == 16) check("ovf_at16", 32'(wr_ovf), 32'd1);
    end
    for (int i = 0; i < 16; i++) pop_expect($sformatf("drain%0d", i), 16'(i));
    settle_empty("drain");
    check("ovf_sticky", 32'(wr_ovf), 32'd1);

    // Clear the sticky flag before continuing
    @(posedge wr_clk); arst = 1'b1;
    repeat (2) @(posedge rd_clk);
    @(posedge wr_clk); arst = 1'b0;

    // Backpressure: three queued words, consumer stalled 20 cycles
    begin
      logic [15:0] bw[3];
      int n = 0;
      bw[0] = 16'hA001; bw[1] = 16'hB002; bw[2] = 16'hC003;
      for (int i = 0; i < 3; i++) wr_word(sdr_for(bw[i]));
      @(negedge rd_clk);
      while (!dout_vld && n < 50) begin @(negedge rd_clk); n++; end
      for (int c = 0; c < 20; c++) begin
        @(negedge rd_clk);
        check("bp_hold_vld",  32'(dout_vld), 32'd1);
        check("bp_hold_dout", 32'(dout),     32'(bw[0]));
      end
      for (int k = 0; k < 3; k++) begin
        check($sformatf("bp_pop%0d_vld", k), 32'(dout_vld), 32'd1);
        check($sformatf("bp_pop%0d", k),     32'(dout),     32'(bw[k]));
        dout_rdy = 1'b1;
        @(negedge rd_clk);
      end
      dout_rdy = 1'b0;
      check("bp_empty", 32'(rd_empty), 32'd1);
    end

    // Latency from write edge to dout_vld on an empty FIFO
    begin
      int n = 0;
      wr_word(sdr_for(16'h5A5A));
      while (!dout_vld && n < 20) begin @(negedge rd_clk); n++; end
      check("lat_vld",  32'(dout_vld), 32'd1);
      check("lat_le3",  32'((rd_edges - wr_mark) <= 3), 32'd1);
      pop_expect("lat_word", 16'h5A5A);
    end

    // Randomised stream with a scoreboard queue
    begin
      int received = 0;
      fork
        begin
          int i = 0;
          int guard = 0;
          while (i < 1000 && guard < 40000) begin
            @(posedge wr_clk);
            guard++;
            if (!wr_full && $urandom_range(0, 99) < 70) begin
              dq_sdr = sdr_for(16'(i));
              dq_we  = 1'b1;
              mq.push_back(16'(i));
              i++;
            end else begin
              dq_we = 1'b0;
            end
          end
          @(posedge wr_clk);
          dq_we = 1'b0;
        end
        begin
          int guard = 0;
          while (received < 1000 && guard < 12000) begin
            logic rdy;
            @(negedge rd_clk);
            guard++;
            rdy = 1'($urandom_range(0, 1));
            if (dout_vld && rdy) begin
              if (mq.size() == 0) begin
                check("rnd_spurious", 32'(dout), 32'hFFFF_FFFF);
              end else begin
                check("rnd_word", 32'(dout), 32'(mq.pop_front()));
              end
              received++;
            end
            dout_rdy = rdy;
          end
          @(negedge rd_clk);
          dout_rdy = 1'b0;
        end
      join
      check("rnd_count", 32'(received), 32'd1000);
      check("rnd_left",  32'(mq.size()), 32'd0);
      check("rnd_wraps", 32'((received / 16) >= 60), 32'd1);
      settle_empty("rnd");
    end

    // Reset mid-operation: 8 words queued and overflow flagged
    for (int i = 0; i < 17; i++) wr_word(sdr_for(16'(16'h0100 + i)));
    for (int i = 0; i < 8; i++) pop_expect($sformatf("pre_rst%0d", i), 16'(16'h0100 + i));
    check("pre_rst_ovf", 32'(wr_ovf), 32'd1);
    @(posedge wr_clk); arst = 1'b1;
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk); arst = 1'b0;
    @(negedge rd_clk);
    check("mrst_vld",   32'(dout_vld), 32'd0);
    check("mrst_empty", 32'(rd_empty), 32'd1);
    check("mrst_full",  32'(wr_full),  32'd0);
    check("mrst_ovf",   32'(wr_ovf),   32'd0);
    check("mrst_dout",  32'(dout),     32'd0);
    wr_word(sdr_for(16'h1234));
    pop_expect("post_rst", 16'h1234);
    settle_empty("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
